// File: rtl/tile_pkg.sv
// Package: tile_pkg
// Shared definitions for the tile write scheduler.
//   tile_t        - 2-bit tile type stored in the tile array
//   TILES_X/Y     - tile array geometry (8x8 tiles)
//   TILE_PX       - tile edge size in pixels
//   sched_state_t - scheduler FSM state encoding
//   tile_idx()    - {y, x} linear tile index
package tile_pkg;

    typedef enum logic [1:0] {
        BG      = 2'b00,
        CLEARED = 2'b01,
        GIFT    = 2'b10,
        WALL    = 2'b11
    } tile_t;

    localparam int unsigned TILES_X    = 8;
    localparam int unsigned TILES_Y    = 8;
    localparam int unsigned TILE_PX    = 80;
    localparam int unsigned TILE_COUNT = TILES_X * TILES_Y;

    typedef logic [1:0] sched_state_t;

    localparam sched_state_t ST_IDLE     = 2'd0;
    localparam sched_state_t ST_LOAD     = 2'd1;
    localparam sched_state_t ST_CLEAR    = 2'd2;
    localparam sched_state_t ST_GAMEOVER = 2'd3;

    function automatic logic [5:0] tile_idx(input logic [2:0] x, input logic [2:0] y);
        return {y, x};
    endfunction

endpackage

// File: rtl/tile_write_scheduler_if.sv
// Interface: tile_write_scheduler_if
// Bundles the gift-removal request handshake and the tile array write port.
//   gift_req/gift_x/gift_y/gift_ready - removal request, accepted on req & ready
//   wr_en/wr_x/wr_y/wr_type           - tile array write strobe and payload
// Modports:
//   slave  - the scheduler (consumes requests, drives the write port)
//   master - the environment (collision logic + tile array)
interface tile_write_scheduler_if;

    logic       gift_req;
    logic [2:0] gift_x;
    logic [2:0] gift_y;
    logic       gift_ready;
    logic       wr_en;
    logic [2:0] wr_x;
    logic [2:0] wr_y;
    logic [1:0] wr_type;

    modport slave (
        input  gift_req, gift_x, gift_y,
        output gift_ready, wr_en, wr_x, wr_y, wr_type
    );

    modport master (
        output gift_req, gift_x, gift_y,
        input  gift_ready, wr_en, wr_x, wr_y, wr_type
    );

endinterface

// File: rtl/gift_fifo.sv
// Module: gift_fifo
// Synchronous FIFO buffering gift-removal requests ({y, x} entries).
// Ports:
//   clk, reset - clock, asynchronous active-high reset
//   i_flush    - discard all entries (wins over push/pop)
//   i_push     - write i_wdata (ignored when full)
//   i_wdata    - entry to write
//   i_pop      - drop head entry (ignored when empty)
//   o_rdata    - head entry (valid when !o_empty)
//   o_full     - no free slot
//   o_empty    - no entry stored
module gift_fifo #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned WIDTH = 6
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             i_flush,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_wdata,
    input  logic             i_pop,
    output logic [WIDTH-1:0] o_rdata,
    output logic             o_full,
    output logic             o_empty
);

    localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CW = AW + 1;

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [CW-1:0]    r_count;

    logic w_push;
    logic w_pop;

    // Flags come straight from the registered occupancy count.
    assign o_full  = (r_count == CW'(DEPTH));
    assign o_empty = (r_count == '0);
    assign o_rdata = r_mem[r_rd_ptr];

    assign w_push = i_push & ~o_full & ~i_flush;
    assign w_pop  = i_pop & ~o_empty & ~i_flush;

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= i_wdata;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else if (i_flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + AW'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + AW'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/tile_write_scheduler.sv
// Module: tile_write_scheduler
// Owns the single write port of the 8x8 tile array and sequences three
// writers onto it: the level-load sweep from the level ROM, buffered
// gift-removal requests, and the end-game clear sweep. Tracks which tiles
// still hold a gift and reports when the last one is removed.
// Ports:
//   clk, reset        - clock, asynchronous active-high reset
//   start_level       - pulse: load level level_id into the array
//   level_id          - level to load, sampled with start_level
//   rom_addr          - {level, tile index} to the level ROM
//   rom_data          - tile type, valid one clk after rom_addr
//   end_game          - pulse: abort activity and clear the array
//   bus               - gift request handshake + tile array write port
//   busy              - LOAD or CLEAR sweep in progress
//   load_done         - 1-clk pulse with the registered write of the last tile
//   gift_count        - gifts still present (0..64)
//   all_gifts_cleared - 1-clk pulse when a removal takes gift_count to 0
module tile_write_scheduler
    import tile_pkg::*;
#(
    parameter int unsigned FIFO_DEPTH = 4,
    parameter int unsigned LEVEL_BITS = 2
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start_level,
    input  logic [LEVEL_BITS-1:0] level_id,
    output logic [LEVEL_BITS+5:0] rom_addr,
    input  logic [1:0]            rom_data,
    input  logic                  end_game,
    tile_write_scheduler_if.slave bus,
    output logic                  busy,
    output logic                  load_done,
    output logic [6:0]            gift_count,
    output logic                  all_gifts_cleared
);

    // LOAD runs one extra clk beyond the last address to absorb ROM latency.
    localparam logic [6:0] LOAD_LAST  = 7'(TILE_COUNT);
    localparam logic [6:0] CLEAR_LAST = 7'(TILE_COUNT - 1);
    localparam logic [6:0] COUNT_MAX  = 7'(TILE_COUNT);

    sched_state_t          r_state;
    sched_state_t          w_next_state;
    logic [LEVEL_BITS-1:0] r_level;
    logic [6:0]            r_cnt;
    logic [5:0]            r_rom_idx;
    logic [63:0]           r_bitmap;
    logic [6:0]            r_gift_count;
    logic                  r_accept;
    logic                  r_wr_en;
    logic [2:0]            r_wr_x;
    logic [2:0]            r_wr_y;
    logic [1:0]            r_wr_type;
    logic                  r_load_done;
    logic                  r_all_clr;

    logic       w_enter_clear;
    logic       w_start;
    logic       w_pop;
    logic       w_push;
    logic       w_full;
    logic       w_empty;
    logic [5:0] w_head;
    logic       w_head_hit;

    assign w_enter_clear = end_game & ((r_state == ST_IDLE) | (r_state == ST_LOAD));
    assign w_start       = start_level & ~w_enter_clear & (r_state != ST_CLEAR);
    assign w_pop         = (r_state == ST_IDLE) & ~w_empty & ~end_game & ~start_level;
    assign w_push        = bus.gift_req & bus.gift_ready;
    assign w_head_hit    = r_bitmap[w_head];

    gift_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (6)
    ) u_gift_fifo (
        .clk     (clk),
        .reset   (reset),
        .i_flush (w_enter_clear),
        .i_push  (w_push),
        .i_wdata (tile_idx(bus.gift_x, bus.gift_y)),
        .i_pop   (w_pop),
        .o_rdata (w_head),
        .o_full  (w_full),
        .o_empty (w_empty)
    );

    assign rom_addr          = {r_level, r_cnt[5:0]};
    assign busy              = (r_state == ST_LOAD) | (r_state == ST_CLEAR);
    assign load_done         = r_load_done;
    assign gift_count        = r_gift_count;
    assign all_gifts_cleared = r_all_clr;
    // r_accept is 0 in reset and in CLEAR/GAMEOVER, so ready is too.
    assign bus.gift_ready    = r_accept & ~w_full;
    assign bus.wr_en         = r_wr_en;
    assign bus.wr_x          = r_wr_x;
    assign bus.wr_y          = r_wr_y;
    assign bus.wr_type       = r_wr_type;

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            ST_IDLE: begin
                if (end_game) begin
                    w_next_state = ST_CLEAR;
                end else if (start_level) begin
                    w_next_state = ST_LOAD;
                end
            end
            ST_LOAD: begin
                if (end_game) begin
                    w_next_state = ST_CLEAR;
                end else if (start_level) begin
                    w_next_state = ST_LOAD;
                end else if (r_cnt == LOAD_LAST) begin
                    w_next_state = ST_IDLE;
                end
            end
            ST_CLEAR: begin
                if (r_cnt == CLEAR_LAST) begin
                    w_next_state = ST_GAMEOVER;
                end
            end
            ST_GAMEOVER: begin
                if (start_level) begin
                    w_next_state = ST_LOAD;
                end
            end
            default: w_next_state = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state      <= ST_IDLE;
            r_level      <= '0;
            r_cnt        <= '0;
            r_rom_idx    <= '0;
            r_bitmap     <= '0;
            r_gift_count <= '0;
            r_accept     <= 1'b0;
            r_wr_en      <= 1'b0;
            r_wr_x       <= '0;
            r_wr_y       <= '0;
            r_wr_type    <= '0;
            r_load_done  <= 1'b0;
            r_all_clr    <= 1'b0;
        end else begin
            r_state     <= w_next_state;
            r_accept    <= (w_next_state == ST_IDLE) | (w_next_state == ST_LOAD);
            r_wr_en     <= 1'b0;
            r_load_done <= 1'b0;
            r_all_clr   <= 1'b0;

            if (w_enter_clear) begin
                r_cnt        <= '0;
                r_bitmap     <= '0;
                r_gift_count <= '0;
            end else if (w_start) begin
                r_level      <= level_id;
                r_cnt        <= '0;
                r_bitmap     <= '0;
                r_gift_count <= '0;
            end else begin
                case (r_state)
                    ST_LOAD: begin
                        // r_rom_idx is the address whose data is on rom_data now.
                        r_rom_idx <= r_cnt[5:0];
                        if (r_cnt != '0) begin
                            r_wr_en   <= 1'b1;
                            r_wr_x    <= r_rom_idx[2:0];
                            r_wr_y    <= r_rom_idx[5:3];
                            r_wr_type <= rom_data;
                            if ((rom_data == GIFT) && (r_gift_count != COUNT_MAX)) begin
                                r_bitmap[r_rom_idx] <= 1'b1;
                                r_gift_count        <= r_gift_count + 7'd1;
                            end
                        end
                        if (r_cnt == LOAD_LAST) begin
                            r_load_done <= 1'b1;
                            r_cnt       <= '0;
                        end else begin
                            r_cnt <= r_cnt + 7'd1;
                        end
                    end
                    ST_CLEAR: begin
                        r_wr_en   <= 1'b1;
                        r_wr_x    <= r_cnt[2:0];
                        r_wr_y    <= r_cnt[5:3];
                        r_wr_type <= BG;
                        r_cnt     <= (r_cnt == CLEAR_LAST) ? 7'd0 : r_cnt + 7'd1;
                    end
                    ST_IDLE: begin
                        // Entries whose bit is already clear are dropped silently.
                        if (w_pop && w_head_hit) begin
                            r_wr_en          <= 1'b1;
                            r_wr_x           <= w_head[2:0];
                            r_wr_y           <= w_head[5:3];
                            r_wr_type        <= CLEARED;
                            r_bitmap[w_head] <= 1'b0;
                            if (r_gift_count != '0) begin
                                r_gift_count <= r_gift_count - 7'd1;
                                if (r_gift_count == 7'd1) begin
                                    r_all_clr <= 1'b1;
                                end
                            end
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_tile_write_scheduler.sv
// Testbench: tb_tile_write_scheduler
// Directed test of tile_write_scheduler with a synchronous level ROM model.
// Level 1: GIFT at idx 9 and 20, WALL elsewhere.
// Level 2: GIFT at idx 0..5 and 9, BG elsewhere.
module tb_tile_write_scheduler;

    logic       clk = 1'b0;
    logic       reset;
    logic       start_level;
    logic [1:0] level_id;
    logic [7:0] rom_addr;
    logic [1:0] rom_data = 2'b00;
    logic       end_game;
    logic       busy;
    logic       load_done;
    logic [6:0] gift_count;
    logic       all_gifts_cleared;

    logic [1:0] rom [256];

    int total = 0;
    int bad   = 0;

    tile_write_scheduler_if bus ();

    tile_write_scheduler #(
        .FIFO_DEPTH (4),
        .LEVEL_BITS (2)
    ) dut (
        .clk               (clk),
        .reset             (reset),
        .start_level       (start_level),
        .level_id          (level_id),
        .rom_addr          (rom_addr),
        .rom_data          (rom_data),
        .end_game          (end_game),
        .bus               (bus),
        .busy              (busy),
        .load_done         (load_done),
        .gift_count        (gift_count),
        .all_gifts_cleared (all_gifts_cleared)
    );

    always #5 clk = ~clk;

    always @(posedge clk) rom_data <= rom[rom_addr];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_load_done(input string tag);
        int  k;
        logic seen;
        k    = 0;
        seen = 1'b0;
        while (!seen && k < 100) begin
            step();
            k++;
            seen = load_done;
        end
        chk(tag, seen, 1);
    endtask

    initial begin
        for (int i = 0; i < 256; i++) rom[i] = 2'b11;
        for (int i = 128; i < 192; i++) rom[i] = 2'b00;
        rom[8'h49] = 2'b10;
        rom[8'h54] = 2'b10;
        for (int i = 0; i < 6; i++) rom[8'h80 + i] = 2'b10;
        rom[8'h89] = 2'b10;

        reset        = 1'b1;
        start_level  = 1'b0;
        level_id     = 2'd0;
        end_game     = 1'b0;
        bus.gift_req = 1'b0;
        bus.gift_x   = 3'd0;
        bus.gift_y   = 3'd0;

        // Reset state
        step();
        step();
        chk("rst_wr_en", bus.wr_en, 0);
        chk("rst_busy", busy, 0);
        chk("rst_ready", bus.gift_ready, 0);
        chk("rst_count", gift_count, 0);
        chk("rst_rom_addr", rom_addr, 0);
        chk("rst_load_done", load_done, 0);
        chk("rst_all_clr", all_gifts_cleared, 0);
        reset = 1'b0;
        step();
        chk("idle_ready", bus.gift_ready, 1);

        // 1: level 1 load sweep
        level_id    = 2'd1;
        start_level = 1'b1;
        step();
        start_level = 1'b0;
        chk("t1_busy", busy, 1);
        for (int c = 0; c <= 64; c++) begin
            if (c <= 63) chk("t1_rom_addr", rom_addr, 32'h40 + c);
            step();
            if (c == 0) begin
                chk("t1_wr_en_c0", bus.wr_en, 0);
            end else begin
                chk("t1_wr_en", bus.wr_en, 1);
                chk("t1_wr_x", bus.wr_x, (c - 1) % 8);
                chk("t1_wr_y", bus.wr_y, (c - 1) / 8);
                chk("t1_wr_type", bus.wr_type, ((c - 1) == 9 || (c - 1) == 20) ? 2 : 3);
            end
            chk("t1_load_done", load_done, (c == 64) ? 1 : 0);
        end
        chk("t1_count", gift_count, 2);
        chk("t1_busy_end", busy, 0);

        // 2: remove (1,1) then (4,2)
        chk("t2_ready", bus.gift_ready, 1);
        bus.gift_req = 1'b1; bus.gift_x = 3'd1; bus.gift_y = 3'd1;
        step();
        bus.gift_req = 1'b0;
        chk("t2_no_wr_yet", bus.wr_en, 0);
        step();
        chk("t2a_wr_en", bus.wr_en, 1);
        chk("t2a_wr_x", bus.wr_x, 1);
        chk("t2a_wr_y", bus.wr_y, 1);
        chk("t2a_type", bus.wr_type, 1);
        chk("t2a_count", gift_count, 1);
        chk("t2a_all_clr", all_gifts_cleared, 0);
        bus.gift_req = 1'b1; bus.gift_x = 3'd4; bus.gift_y = 3'd2;
        step();
        bus.gift_req = 1'b0;
        step();
        chk("t2b_wr_en", bus.wr_en, 1);
        chk("t2b_wr_x", bus.wr_x, 4);
        chk("t2b_wr_y", bus.wr_y, 2);
        chk("t2b_type", bus.wr_type, 1);
        chk("t2b_count", gift_count, 0);
        chk("t2b_all_clr", all_gifts_cleared, 1);
        step();
        chk("t2c_all_clr", all_gifts_cleared, 0);
        chk("t2c_wr_en", bus.wr_en, 0);
        chk("t2c_hold_x", bus.wr_x, 4);
        chk("t2c_hold_type", bus.wr_type, 1);

        // 3: five requests during a level 2 load, depth 4
        level_id    = 2'd2;
        start_level = 1'b1;
        step();
        start_level = 1'b0;
        for (int i = 0; i < 5; i++) begin
            chk("t3_ready", bus.gift_ready, (i < 4) ? 1 : 0);
            bus.gift_req = 1'b1; bus.gift_x = 3'(i); bus.gift_y = 3'd0;
            step();
        end
        bus.gift_req = 1'b0;
        chk("t3_busy_held", busy, 1);
        wait_load_done("t3_load_done_seen");
        chk("t3_count_loaded", gift_count, 7);
        for (int k = 0; k < 4; k++) begin
            step();
            chk("t3_pop_wr_en", bus.wr_en, 1);
            chk("t3_pop_x", bus.wr_x, k);
            chk("t3_pop_y", bus.wr_y, 0);
            chk("t3_pop_type", bus.wr_type, 1);
            chk("t3_pop_count", gift_count, 6 - k);
        end
        step();
        chk("t3_fifo_drained", bus.wr_en, 0);
        chk("t3_count_end", gift_count, 3);

        // 4: duplicate (1,1)
        bus.gift_req = 1'b1; bus.gift_x = 3'd1; bus.gift_y = 3'd1;
        step();
        chk("t4_first_push_no_wr", bus.wr_en, 0);
        step();
        bus.gift_req = 1'b0;
        chk("t4_wr_en", bus.wr_en, 1);
        chk("t4_wr_x", bus.wr_x, 1);
        chk("t4_wr_y", bus.wr_y, 1);
        chk("t4_count", gift_count, 2);
        step();
        chk("t4_dup_no_wr", bus.wr_en, 0);
        chk("t4_dup_count", gift_count, 2);
        chk("t4_all_clr", all_gifts_cleared, 0);

        // 5: end_game at LOAD idx 30, start_level ignored in CLEAR
        level_id    = 2'd1;
        start_level = 1'b1;
        step();
        start_level = 1'b0;
        bus.gift_req = 1'b1; bus.gift_x = 3'd1; bus.gift_y = 3'd1;
        step();
        bus.gift_req = 1'b0;
        for (int i = 1; i < 30; i++) step();
        chk("t5_rom_addr_30", rom_addr, 32'h5E);
        end_game = 1'b1;
        step();
        end_game = 1'b0;
        chk("t5_no_rom_wr", bus.wr_en, 0);
        chk("t5_busy", busy, 1);
        chk("t5_ready", bus.gift_ready, 0);
        chk("t5_count", gift_count, 0);
        for (int k = 0; k < 64; k++) begin
            if (k == 10) start_level = 1'b1;
            step();
            start_level = 1'b0;
            chk("t5_clr_wr_en", bus.wr_en, 1);
            chk("t5_clr_x", bus.wr_x, k % 8);
            chk("t5_clr_y", bus.wr_y, k / 8);
            chk("t5_clr_type", bus.wr_type, 0);
        end
        chk("t5_gameover_busy", busy, 0);
        chk("t5_gameover_ready", bus.gift_ready, 0);
        bus.gift_req = 1'b1;
        step();
        bus.gift_req = 1'b0;
        chk("t5_gameover_wr_en", bus.wr_en, 0);
        chk("t5_gameover_ready2", bus.gift_ready, 0);
        start_level = 1'b1;
        step();
        start_level = 1'b0;
        chk("t5_restart_busy", busy, 1);
        wait_load_done("t5_reload_done_seen");
        chk("t5_reload_count", gift_count, 2);
        step();
        chk("t5_flushed_no_pop", bus.wr_en, 0);

        // 6: reset mid-CLEAR
        end_game = 1'b1;
        step();
        end_game = 1'b0;
        for (int i = 0; i < 10; i++) step();
        chk("t6_clearing", bus.wr_en, 1);
        reset = 1'b1;
        #1;
        chk("t6_rst_wr_en", bus.wr_en, 0);
        chk("t6_rst_busy", busy, 0);
        chk("t6_rst_rom_addr", rom_addr, 0);
        chk("t6_rst_count", gift_count, 0);
        chk("t6_rst_ready", bus.gift_ready, 0);
        chk("t6_rst_wr_x", bus.wr_x, 0);
        step();
        reset = 1'b0;
        step();
        chk("t6_idle_busy", busy, 0);
        chk("t6_idle_ready", bus.gift_ready, 1);
        chk("t6_idle_wr_en", bus.wr_en, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
